// File: rtl/aes_pkg.sv
// Shared AES helpers: ShiftRows row offsets per block width and the legal-NB check.
package aes_pkg;

    // Row offsets C_r; only the 256-bit block (NB=8) widens rows 2 and 3.
    function automatic int row_offset(input int nb, input int row);
        if (nb == 8 && row >= 2) begin
            return row + 1;
        end
        return row;
    endfunction

    function automatic bit nb_is_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation over an NB-column state.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] data_i,
    input  logic             inv_i,
    output logic [32*NB-1:0] data_o
);

    // Pure wiring: each output byte picks one of two fixed source bytes.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int OFF = row_offset(NB, r);
            localparam int FWD = (c + OFF) % NB;
            localparam int BWD = (c + NB - OFF) % NB;
            assign data_o[8*(4*c+r) +: 8] = inv_i ? data_i[8*(4*BWD+r) +: 8]
                                                  : data_i[8*(4*FWD+r) +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows stage: permutes on the input side, then buffers results in a 2-entry FIFO.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic              out_inv,
    output logic [1:0]        level
);

    localparam int W = 32 * NB;

    if (!nb_is_legal(NB)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    logic [W-1:0] permData;
    logic [W-1:0] memData_q [2];
    logic         memInv_q  [2];
    logic         wrPtr_q, wrPtr_d;
    logic         rdPtr_q, rdPtr_d;
    logic [1:0]   level_q, level_d;
    logic         push, pop;

    shift_rows_perm #(.NB(NB)) u_perm (
        .data_i (in_data),
        .inv_i  (in_inv),
        .data_o (permData)
    );

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (level_q != 2'd2) && !rst;
    assign out_valid = (level_q != 2'd0);
    assign out_data  = memData_q[rdPtr_q];
    assign out_inv   = memInv_q[rdPtr_q];
    assign level     = level_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (push) begin
            wrPtr_d = ~wrPtr_q;
        end
        if (pop) begin
            rdPtr_d = ~rdPtr_q;
        end
        if (push && !pop) begin
            level_d = level_q + 2'd1;
        end else if (pop && !push) begin
            level_d = level_q - 2'd1;
        end
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q      <= 2'd0;
            wrPtr_q      <= 1'b0;
            rdPtr_q      <= 1'b0;
            memData_q[0] <= '0;
            memData_q[1] <= '0;
            memInv_q[0]  <= 1'b0;
            memInv_q[1]  <= 1'b0;
        end else begin
            level_q <= level_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            if (push) begin
                memData_q[wrPtr_q] <= permData;
                memInv_q[wrPtr_q]  <= in_inv;
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Randomised and directed checks of shift_rows_pipe against a byte-grid reference model.
module tb_shift_rows_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_inv;
    logic [127:0] in_data;
    logic         out_valid, out_ready, out_inv;
    logic [127:0] out_data;
    logic [1:0]   level;

    logic         v6In, r6In, i6In, v6Out, r6Out, i6Out;
    logic [191:0] d6In, d6Out;
    logic [1:0]   l6;
    logic         v8In, r8In, i8In, v8Out, r8Out, i8Out;
    logic [255:0] d8In, d8Out;
    logic [1:0]   l8;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [127:0] d;
        logic         inv;
    } beat_t;
    beat_t modelQ[$];

    always #5 clk = ~clk;

    shift_rows_pipe #(.NB(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv), .level(level)
    );

    shift_rows_pipe #(.NB(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(v6In), .in_ready(r6In),
        .in_data(d6In), .in_inv(i6In), .out_valid(v6Out),
        .out_ready(r6Out), .out_data(d6Out), .out_inv(i6Out), .level(l6)
    );

    shift_rows_pipe #(.NB(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8In), .in_ready(r8In),
        .in_data(d8In), .in_inv(i8In), .out_valid(v8Out),
        .out_ready(r8Out), .out_data(d8Out), .out_inv(i8Out), .level(l8)
    );

    // Reference ShiftRows: view the state as a 4 x nb byte grid and rotate each row.
    function automatic logic [255:0] permRef(input int nb, input logic [255:0] din, input bit inv);
        int          offs[4];
        logic [7:0]  grid[4][8];
        logic [255:0] res;
        int          src;
        if (nb == 8) offs = '{0, 1, 3, 4};
        else         offs = '{0, 1, 2, 3};
        res = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                grid[r][c] = din[8*(4*c+r) +: 8];
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - offs[r] + nb) % nb : (c + offs[r]) % nb;
                res[8*(4*c+r) +: 8] = grid[r][src];
            end
        return res;
    endfunction

    function automatic logic [127:0] randState();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance one clock and update the model from the handshake the spec implies.
    task automatic advance();
        bit    acc, pp, wasRst;
        beat_t b;
        wasRst = rst;
        acc = in_valid && !rst && (modelQ.size() < 2);
        pp  = out_ready && (modelQ.size() > 0);
        b.d   = permRef(4, {128'b0, in_data}, in_inv)[127:0];
        b.inv = in_inv;
        @(posedge clk);
        if (wasRst) modelQ.delete();
        else begin
            if (pp)  void'(modelQ.pop_front());
            if (acc) modelQ.push_back(b);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; in_data = randState(); in_inv = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        nCompared++;
        if (in_ready !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL reset_in_ready got=%b want=0", in_ready);
        end
        advance();
        nCompared++;
        if (level !== 2'd0 || out_valid !== 1'b0 || out_data !== 128'b0 || out_inv !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_state got level=%0d valid=%b data=%h inv=%b want 0/0/0/0",
                     level, out_valid, out_data, out_inv);
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL post_reset_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_fips();
        logic [7:0]   fIn[16]  = '{8'hd4,8'h27,8'h11,8'hae,8'he0,8'hbf,8'h98,8'hf1,
                                   8'hb8,8'hb4,8'h5d,8'he5,8'h1e,8'h41,8'h52,8'h30};
        logic [7:0]   fOut[16] = '{8'hd4,8'hbf,8'h5d,8'h30,8'he0,8'hb4,8'h52,8'hae,
                                   8'hb8,8'h41,8'h11,8'hf1,8'h1e,8'h27,8'h98,8'he5};
        logic [127:0] vIn, vOut;
        for (int k = 0; k < 16; k++) begin
            vIn[8*k +: 8]  = fIn[k];
            vOut[8*k +: 8] = fOut[k];
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = vIn; in_inv = 1'b0;
        advance();
        nCompared++;
        if (out_valid !== 1'b1 || out_data !== vOut || out_inv !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL fips_fwd got valid=%b data=%h inv=%b want 1 %h 0",
                     out_valid, out_data, out_inv, vOut);
        end
        in_data = vOut; in_inv = 1'b1;
        advance();
        nCompared++;
        if (out_valid !== 1'b1 || out_data !== vIn || out_inv !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL fips_inv got valid=%b data=%h inv=%b want 1 %h 1",
                     out_valid, out_data, out_inv, vIn);
        end
        in_valid = 1'b0;
        advance();
    endtask

    task automatic test_wide();
        logic [255:0] ramp;
        logic [255:0] exp8, exp6;
        for (int k = 0; k < 32; k++) ramp[8*k +: 8] = 8'(k);
        exp8 = permRef(8, ramp, 1'b0);
        exp6 = permRef(6, ramp, 1'b0);
        d8In = ramp; i8In = 1'b0; v8In = 1'b1; r8Out = 1'b1;
        d6In = ramp[191:0]; i6In = 1'b0; v6In = 1'b1; r6Out = 1'b1;
        @(posedge clk); #1;
        v8In = 1'b0; v6In = 1'b0;
        nCompared++;
        if (v8Out !== 1'b1 || d8Out[31:24] !== 8'h13 || d8Out[15:8] !== 8'h05 ||
            d8Out[23:16] !== 8'h0E || d8Out[255:248] !== 8'h0F) begin
            nMismatched++;
            $display("[TB] FAIL nb8_bytes got valid=%b b3=%h b1=%h b2=%h b31=%h want 1 13 05 0e 0f",
                     v8Out, d8Out[31:24], d8Out[15:8], d8Out[23:16], d8Out[255:248]);
        end
        nCompared++;
        if (d8Out !== exp8) begin
            nMismatched++; $display("[TB] FAIL nb8_full got=%h want=%h", d8Out, exp8);
        end
        nCompared++;
        if (v6Out !== 1'b1 || d6Out[191:184] !== 8'h0B || d6Out !== exp6[191:0]) begin
            nMismatched++;
            $display("[TB] FAIL nb6_full got valid=%b data=%h want 1 %h", v6Out, d6Out, exp6[191:0]);
        end
        d8In = ramp; i8In = 1'b1; v8In = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        v8In = 1'b0;
        nCompared++;
        if (d8Out !== permRef(8, ramp, 1'b1) || i8Out !== 1'b1) begin
            nMismatched++; $display("[TB] FAIL nb8_inv got=%h inv=%b", d8Out, i8Out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [127:0] beat[3];
        logic [127:0] expHead;
        for (int i = 0; i < 3; i++) beat[i] = randState();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data = beat[i];
            advance();
        end
        expHead = permRef(4, {128'b0, beat[0]}, 1'b0)[127:0];
        for (int s = 0; s < 3; s++) begin
            nCompared++;
            if (level !== 2'd2 || in_ready !== 1'b0 || out_data !== expHead || out_valid !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL bp_stall got level=%0d ready=%b data=%h want 2 0 %h",
                         level, in_ready, out_data, expHead);
            end
            advance();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expHead = permRef(4, {128'b0, beat[i]}, 1'b0)[127:0];
            nCompared++;
            if (out_valid !== 1'b1 || out_data !== expHead) begin
                nMismatched++;
                $display("[TB] FAIL bp_order[%0d] got valid=%b data=%h want 1 %h",
                         i, out_valid, out_data, expHead);
            end
            advance();
            if (i == 1) in_valid = 1'b0;
        end
        nCompared++;
        if (out_valid !== 1'b0 || level !== 2'd0) begin
            nMismatched++; $display("[TB] FAIL bp_drain got valid=%b level=%0d want 0 0", out_valid, level);
        end
    endtask

    task automatic test_streaming();
        int seen = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = randState();
            in_inv  = i[0];
            advance();
            nCompared++;
            if (modelQ.size() == 1 && out_valid === 1'b1 && level === 2'd1 &&
                out_data === modelQ[0].d && out_inv === modelQ[0].inv && out_inv === i[0]) begin
                seen++;
            end else begin
                nMismatched++;
                $display("[TB] FAIL stream[%0d] got valid=%b level=%0d data=%h inv=%b", i,
                         out_valid, level, out_data, out_inv);
            end
        end
        in_valid = 1'b0;
        advance();
        nCompared++;
        if (seen != 16 || out_valid !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL stream_count got=%0d valid=%b want 16 0", seen, out_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            in_data   = randState();
            in_inv    = 1'($urandom);
            #1;
            nCompared++;
            if (in_ready !== (modelQ.size() != 2) || level !== 2'(modelQ.size()) ||
                out_valid !== (modelQ.size() != 0)) begin
                nMismatched++;
                $display("[TB] FAIL rand_ctrl[%0d] got ready=%b level=%0d valid=%b want size=%0d",
                         n, in_ready, level, out_valid, modelQ.size());
            end else if (modelQ.size() != 0) begin
                nCompared++;
                if (out_data !== modelQ[0].d || out_inv !== modelQ[0].inv) begin
                    nMismatched++;
                    $display("[TB] FAIL rand_data[%0d] got=%h/%b want=%h/%b",
                             n, out_data, out_inv, modelQ[0].d, modelQ[0].inv);
                end
            end
            advance();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        advance(); advance();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b1;
        in_data = randState(); advance();
        in_data = randState(); advance();
        nCompared++;
        if (level !== 2'd2) begin
            nMismatched++; $display("[TB] FAIL mid_fill got level=%0d want 2", level);
        end
        rst = 1'b1;
        #1;
        nCompared++;
        if (in_ready !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL mid_rst_ready got=%b want 0", in_ready);
        end
        advance();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        nCompared++;
        if (level !== 2'd0 || out_valid !== 1'b0 || out_data !== 128'b0 || in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL mid_rst_state got level=%0d valid=%b data=%h ready=%b want 0 0 0 1",
                     level, out_valid, out_data, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            advance();
            nCompared++;
            if (out_valid !== 1'b0) begin
                nMismatched++; $display("[TB] FAIL mid_stale[%0d] got valid=%b want 0", i, out_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
        v6In = 1'b0; d6In = '0; i6In = 1'b0; r6Out = 1'b0;
        v8In = 1'b0; d8In = '0; i8In = 1'b0; r8Out = 1'b0;
        test_reset();
        test_fips();
        test_wide();
        test_backpressure();
        test_streaming();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
